// File: rtl/psum_out_router_buf.sv
// Buffered multi-lane psum router: ID-matched PE beats are queued in a small FIFO and drained onto the shared bus.
// Optional PSUM_ROUTER_BEAT_CNT_EN adds a saturating per-transfer popped-beat counter output.
module psum_out_router_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int LANES      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        config_state,
    input  logic                        ce,
    input  logic [ID_WIDTH-1:0]         dest_id,
    input  logic [ID_WIDTH-1:0]         source_id,
    input  logic [LANES*DATA_WIDTH-1:0] data_from_pe,
    input  logic                        data_from_pe_en,
    input  logic                        psum_last,
    output logic                        pe_ready,
    input  logic                        psum_out_start_in,
    output logic                        psum_out_start_out,
    output logic [LANES*DATA_WIDTH-1:0] data_to_bus,
    output logic                        data_to_bus_en,
    input  logic                        bus_ready,
    output logic                        psum_done,
    output logic                        overflow_err,
    output logic                        proto_err
`ifdef PSUM_ROUTER_BEAT_CNT_EN
    ,
    output logic [15:0]                 psum_beat_cnt
`endif
);

    localparam int BEAT_W = LANES * DATA_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [ID_WIDTH-1:0] stored_id_q, stored_id_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pe_ready_q, pe_ready_d;
    logic               start_out_q, start_out_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               proto_q, proto_d;
    logic [BEAT_W-1:0]  mem_q [FIFO_DEPTH];

    logic match, beat, full, empty, push, pop, start_acc;

    always_comb begin
        stored_id_d = stored_id_q;
        if (config_state && ce) stored_id_d = dest_id;

        match     = (stored_id_q == source_id) && !config_state;
        beat      = match && data_from_pe_en;
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        empty     = (count_q == '0);
        push      = (state_q == S_ACTIVE) && beat && !full;
        pop       = !empty && bus_ready;
        start_acc = (state_q == S_IDLE) && match && psum_out_start_in;

        state_d     = state_q;
        start_out_d = 1'b0;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        proto_d     = proto_q;
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);

        case (state_q)
            S_IDLE: begin
                if (beat) proto_d = 1'b1;
                if (start_acc) begin
                    state_d     = S_ACTIVE;
                    start_out_d = 1'b1;
                end
            end
            S_ACTIVE: begin
                // A dropped final beat still closes the transfer.
                if (beat && full) ovf_d = 1'b1;
                if (beat && psum_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (beat) proto_d = 1'b1;
                if (count_d == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Entering configuration mid-transfer abandons it silently.
        if (config_state && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            done_d      = 1'b0;
            start_out_d = 1'b0;
        end

        pe_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stored_id_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pe_ready_q  <= 1'b1;
            start_out_q <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            proto_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stored_id_q <= stored_id_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pe_ready_q  <= pe_ready_d;
            start_out_q <= start_out_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            proto_q     <= proto_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_from_pe;
    end

    assign data_to_bus        = empty ? '0 : mem_q[rd_ptr_q];
    assign data_to_bus_en     = !empty;
    assign pe_ready           = pe_ready_q;
    assign psum_out_start_out = start_out_q;
    assign psum_done          = done_q;
    assign overflow_err       = ovf_q;
    assign proto_err          = proto_q;

`ifdef PSUM_ROUTER_BEAT_CNT_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (start_acc)
            beat_cnt_d = '0;
        else if (pop && (beat_cnt_q != 16'hFFFF))
            beat_cnt_d = beat_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) beat_cnt_q <= '0;
        else     beat_cnt_q <= beat_cnt_d;
    end

    assign psum_beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_psum_out_router_buf.sv
// Directed bench for psum_out_router_buf: a cycle table for config/basic transfer, then hand sequences for corner cases.
module tb_psum_out_router_buf;

    logic        clk = 1'b0;
    logic        rst, config_state, ce;
    logic [7:0]  dest_id, source_id;
    logic [31:0] data_from_pe;
    logic        data_from_pe_en, psum_last, pe_ready;
    logic        psum_out_start_in, psum_out_start_out;
    logic [31:0] data_to_bus;
    logic        data_to_bus_en, bus_ready, psum_done, overflow_err, proto_err;
`ifdef PSUM_ROUTER_BEAT_CNT_EN
    logic [15:0] beat_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    psum_out_router_buf #(.DATA_WIDTH(16), .ID_WIDTH(8), .LANES(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .config_state(config_state), .ce(ce),
        .dest_id(dest_id), .source_id(source_id),
        .data_from_pe(data_from_pe), .data_from_pe_en(data_from_pe_en),
        .psum_last(psum_last), .pe_ready(pe_ready),
        .psum_out_start_in(psum_out_start_in), .psum_out_start_out(psum_out_start_out),
        .data_to_bus(data_to_bus), .data_to_bus_en(data_to_bus_en),
        .bus_ready(bus_ready), .psum_done(psum_done),
        .overflow_err(overflow_err), .proto_err(proto_err)
`ifdef PSUM_ROUTER_BEAT_CNT_EN
        , .psum_beat_cnt(beat_cnt)
`endif
    );

    typedef struct {
        logic        rst, cfg, ce;
        logic [7:0]  did, sid;
        logic [31:0] data;
        logic        en, last, start, brdy;
        logic        e_rdy, e_sout;
        logic [31:0] e_data;
        logic        e_den, e_done, e_ovf, e_proto;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 1'b0; config_state = 1'b0; ce = 1'b0; dest_id = 8'h00;
        data_from_pe = 32'h0; data_from_pe_en = 1'b0; psum_last = 1'b0;
        psum_out_start_in = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic sout, input logic [31:0] d,
                           input logic den, input logic done, input logic ovf, input logic prot);
        chk({tag, ".pe_ready"}, 32'(pe_ready), 32'(rdy));
        chk({tag, ".start_out"}, 32'(psum_out_start_out), 32'(sout));
        chk({tag, ".data"}, data_to_bus, d);
        chk({tag, ".data_en"}, 32'(data_to_bus_en), 32'(den));
        chk({tag, ".done"}, 32'(psum_done), 32'(done));
        chk({tag, ".overflow"}, 32'(overflow_err), 32'(ovf));
        chk({tag, ".proto"}, 32'(proto_err), 32'(prot));
    endtask

    initial begin
        quiet();
        source_id = 8'h00;
        bus_ready = 1'b1;

        // rst cfg ce did sid data en last start brdy | rdy sout data den done ovf proto
        vecs.push_back('{1'b1,1'b0,1'b0,8'h00,8'h00,32'h0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,8'h05,8'h00,32'h0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,8'h05,32'h0,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b1,32'h0,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,8'h05,32'h0001_0002,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h0001_0002,1'b1,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,8'h05,32'h0003_0004,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h0003_0004,1'b1,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,8'h05,32'h0005_0006,1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,32'h0005_0006,1'b1,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,8'h05,32'h0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h0,1'b0,1'b1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,8'h05,32'h0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,8'h06,32'h0,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,8'h06,32'hDEAD_BEEF,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,8'h00,8'h06,32'h0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,32'h0,1'b0,1'b0,1'b0,1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; config_state = vecs[i].cfg; ce = vecs[i].ce;
            dest_id = vecs[i].did; source_id = vecs[i].sid;
            data_from_pe = vecs[i].data; data_from_pe_en = vecs[i].en;
            psum_last = vecs[i].last; psum_out_start_in = vecs[i].start;
            bus_ready = vecs[i].brdy;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_sout, vecs[i].e_data,
                    vecs[i].e_den, vecs[i].e_done, vecs[i].e_ovf, vecs[i].e_proto);
        end
`ifdef PSUM_ROUTER_BEAT_CNT_EN
        chk("basic.beat_cnt", 32'(beat_cnt), 32'd3);
`endif

        // Backpressure: fill the FIFO, drop a fifth (last) beat, then drain exactly four.
        quiet();
        source_id = 8'h05; bus_ready = 1'b0; psum_out_start_in = 1'b1;
        tick();
        psum_out_start_in = 1'b0;
        chk("bp.start_out", 32'(psum_out_start_out), 32'd1);
        for (int i = 0; i < 4; i++) begin
            data_from_pe = 32'h10 + 32'(i); data_from_pe_en = 1'b1;
            tick();
            chk($sformatf("bp.pe_ready%0d", i), 32'(pe_ready), (i < 3) ? 32'd1 : 32'd0);
        end
        data_from_pe = 32'h14; psum_last = 1'b1;
        tick();
        chk("bp.overflow", 32'(overflow_err), 32'd1);
        chk("bp.pe_ready_full", 32'(pe_ready), 32'd0);
        data_from_pe_en = 1'b0; psum_last = 1'b0; bus_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp.den%0d", k), 32'(data_to_bus_en), 32'd1);
            chk($sformatf("bp.data%0d", k), data_to_bus, 32'h10 + 32'(k));
            tick();
        end
        chk("bp.empty", 32'(data_to_bus_en), 32'd0);
        chk("bp.done", 32'(psum_done), 32'd1);
        chk("bp.pe_ready_back", 32'(pe_ready), 32'd1);
`ifdef PSUM_ROUTER_BEAT_CNT_EN
        chk("bp.beat_cnt", 32'(beat_cnt), 32'd4);
`endif
        tick();
        chk("bp.done_pulse", 32'(psum_done), 32'd0);

        // Concurrent push/pop holding two beats in flight for ten cycles.
        bus_ready = 1'b0; psum_out_start_in = 1'b1;
        tick();
        psum_out_start_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_from_pe = 32'h100 + 32'(i); data_from_pe_en = 1'b1;
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            bus_ready = 1'b1; data_from_pe_en = 1'b1;
            data_from_pe = 32'h102 + 32'(i); psum_last = (i == 9);
            chk($sformatf("cc.head%0d", i), data_to_bus, 32'h100 + 32'(i));
            chk($sformatf("cc.rdy%0d", i), 32'(pe_ready), 32'd1);
            tick();
        end
        data_from_pe_en = 1'b0; psum_last = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("cc.tail_den%0d", k), 32'(data_to_bus_en), 32'd1);
            chk($sformatf("cc.tail%0d", k), data_to_bus, 32'h10A + 32'(k));
            tick();
        end
        chk("cc.empty", 32'(data_to_bus_en), 32'd0);
        chk("cc.done", 32'(psum_done), 32'd1);
`ifdef PSUM_ROUTER_BEAT_CNT_EN
        chk("cc.beat_cnt", 32'(beat_cnt), 32'd12);
`endif
        tick();

        // Matching beat while idle is a protocol error and is not buffered.
        data_from_pe = 32'hBAD; data_from_pe_en = 1'b1;
        tick();
        data_from_pe_en = 1'b0;
        chk("proto.flag", 32'(proto_err), 32'd1);
        chk("proto.empty", 32'(data_to_bus_en), 32'd0);
        chk("proto.ovf_sticky", 32'(overflow_err), 32'd1);

        // Abort via config_state with two beats buffered.
        psum_out_start_in = 1'b1;
        tick();
        psum_out_start_in = 1'b0; bus_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_from_pe = 32'h200 + 32'(i); data_from_pe_en = 1'b1;
            tick();
        end
        data_from_pe_en = 1'b0;
        chk("abort.pre_den", 32'(data_to_bus_en), 32'd1);
        config_state = 1'b1;
        tick();
        chk("abort.den", 32'(data_to_bus_en), 32'd0);
        chk("abort.data", data_to_bus, 32'h0);
        chk("abort.done", 32'(psum_done), 32'd0);
        config_state = 1'b0;
        tick();
        chk("abort.done_late", 32'(psum_done), 32'd0);
        psum_out_start_in = 1'b1;
        tick();
        psum_out_start_in = 1'b0;
        chk("abort.idle_restart", 32'(psum_out_start_out), 32'd1);

        // Reset in the middle of DRAIN.
        data_from_pe = 32'h300; data_from_pe_en = 1'b1; psum_last = 1'b1;
        tick();
        data_from_pe_en = 1'b0; psum_last = 1'b0;
        tick();
        chk("drain.den", 32'(data_to_bus_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all("rst", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PSUM_ROUTER_BEAT_CNT_EN
        chk("rst.beat_cnt", 32'(beat_cnt), 32'd0);
`endif
        psum_out_start_in = 1'b1;
        tick();
        chk("rst.id_cleared", 32'(psum_out_start_out), 32'd0);
        source_id = 8'h00;
        tick();
        psum_out_start_in = 1'b0;
        chk("rst.id_zero_match", 32'(psum_out_start_out), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
